// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I main control FSM: sequences FETCH..writeback and drives datapath selects/strobes.
// Optional retired-instruction counter o_instret is built when RISCV_INSTRET_COUNTER_EN is defined.
module riscv_multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1
`ifdef RISCV_INSTRET_COUNTER_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memRead,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [3:0] o_aluOp,
    output logic [1:0] o_immSrc,
    output logic       o_illegal,
    output logic [3:0] o_state
`ifdef RISCV_INSTRET_COUNTER_EN
    ,
    output logic [CNT_W-1:0] o_instret
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR = 4'd6, EXECI   = 4'd7,
        ALUWB    = 4'd8,  BEQ    = 4'd9,  JAL    = 4'd10, TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;

    state_t     state_q, state_d;
    logic       rdy_s;
    logic [3:0] exec_op_s;
    logic       exec_ok_s;

    assign rdy_s   = i_memReady | ~MEM_HANDSHAKE;
    assign o_state = state_q;

    // State register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU operation for EXECR/EXECI; unsupported funct3 diverts to TRAP
    always_comb begin
        exec_op_s = ALU_ADD;
        exec_ok_s = 1'b1;
        case (i_funct3)
            3'b000: exec_op_s = (state_q == EXECR && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111: exec_op_s = ALU_AND;
            3'b110: exec_op_s = ALU_OR;
            3'b100: exec_op_s = ALU_XOR;
            default: exec_ok_s = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = rdy_s ? DECODE : FETCH;
            DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_B:         state_d = (i_funct3 == 3'b000) ? BEQ : TRAP;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR:   state_d = (i_opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = rdy_s ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = rdy_s ? FETCH : MEMWRITE;
            EXECR,
            EXECI:    state_d = exec_ok_s ? ALUWB : TRAP;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = TRAP;
        endcase
    end

    // Moore outputs; everything is held at its idle value while reset is asserted
    always_comb begin
        o_pcWrite   = 1'b0;
        o_adrSrc    = 1'b0;
        o_memRead   = 1'b0;
        o_memWrite  = 1'b0;
        o_irWrite   = 1'b0;
        o_regWrite  = 1'b0;
        o_resultSrc = 2'b00;
        o_aluSrcA   = 2'b00;
        o_aluSrcB   = 2'b00;
        o_aluOp     = ALU_ADD;
        o_immSrc    = 2'b00;
        o_illegal   = 1'b0;
        if (!i_arst_n) begin
            o_illegal = 1'b0;
        end else begin
            case (i_opcode)
                OP_SW:   o_immSrc = 2'b01;
                OP_B:    o_immSrc = 2'b10;
                OP_JAL:  o_immSrc = 2'b11;
                default: o_immSrc = 2'b00;
            endcase
            case (state_q)
                FETCH: begin
                    o_memRead   = 1'b1;
                    o_aluSrcB   = 2'b10;
                    o_resultSrc = 2'b10;
                    o_irWrite   = rdy_s;
                    o_pcWrite   = rdy_s;
                end
                DECODE: begin
                    o_aluSrcA = 2'b01;
                    o_aluSrcB = 2'b01;
                end
                MEMADR: begin
                    o_aluSrcA = 2'b10;
                    o_aluSrcB = 2'b01;
                end
                MEMREAD: begin
                    o_adrSrc  = 1'b1;
                    o_memRead = 1'b1;
                end
                MEMWB: begin
                    o_resultSrc = 2'b01;
                    o_regWrite  = 1'b1;
                end
                MEMWRITE: begin
                    o_adrSrc   = 1'b1;
                    o_memWrite = 1'b1;
                end
                EXECR, EXECI: begin
                    o_aluSrcA = 2'b10;
                    o_aluSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
                    o_aluOp   = exec_op_s;
                end
                ALUWB:    o_regWrite = 1'b1;
                BEQ: begin
                    o_aluSrcA = 2'b10;
                    o_aluOp   = ALU_SUB;
                    o_pcWrite = i_zero;
                end
                JAL: begin
                    o_aluSrcA = 2'b01;
                    o_aluSrcB = 2'b10;
                    o_pcWrite = 1'b1;
                end
                TRAP:     o_illegal = 1'b1;
                default:  o_illegal = 1'b1;
            endcase
        end
    end

`ifdef RISCV_INSTRET_COUNTER_EN
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire_s;

    assign retire_s  = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                       ((state_q == MEMWRITE) && rdy_s);
    assign o_instret = instret_q;

    // Retired-instruction count, wraps naturally at 2^CNT_W
    always_comb begin
        if (retire_s) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: expected control vectors queued per step, compared mid-cycle.
module tb_riscv_multicycle_ctrl;

    logic       i_clk = 1'b0;
    logic       i_arst_n;
    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_funct7b5, i_zero, i_memReady;
    logic       o_pcWrite, o_adrSrc, o_memRead, o_memWrite, o_irWrite, o_regWrite, o_illegal;
    logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
    logic [3:0] o_aluOp, o_state;
`ifdef RISCV_INSTRET_COUNTER_EN
    logic [3:0] o_instret;
`endif

    riscv_multicycle_ctrl #(
        .MEM_HANDSHAKE(1'b1)
`ifdef RISCV_INSTRET_COUNTER_EN
        , .CNT_W(4)
`endif
    ) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_memReady(i_memReady),
        .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc), .o_memRead(o_memRead),
        .o_memWrite(o_memWrite), .o_irWrite(o_irWrite), .o_regWrite(o_regWrite),
        .o_resultSrc(o_resultSrc), .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB),
        .o_aluOp(o_aluOp), .o_immSrc(o_immSrc), .o_illegal(o_illegal), .o_state(o_state)
`ifdef RISCV_INSTRET_COUNTER_EN
        , .o_instret(o_instret)
`endif
    );

    always #5 i_clk = ~i_clk;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011, OP_B  = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    // strobe groups ordered {pcWrite, adrSrc, memRead, memWrite, irWrite, regWrite}
    localparam logic [5:0] F_RDY = 6'b101010, F_WAIT = 6'b001000, NONE = 6'b000000;
    localparam logic [5:0] MRD = 6'b011000, MWR = 6'b010100, RW = 6'b000001, PCW = 6'b100000;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, AND_ = 4'b0111, OR_ = 4'b0110, XOR_ = 4'b0100;

    typedef struct {
        string       tag;
        logic [22:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // queue the expected vector, let inputs settle, compare, then advance one clock
    task automatic cyc(input string tag, input logic [3:0] st, input logic [5:0] str,
                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [3:0] op, input logic [1:0] imm, input logic ill);
        exp_t        e;
        logic [22:0] obs;
        e.tag = tag;
        e.v   = {st, str, rs, sa, sb, op, imm, ill};
        sb_q.push_back(e);
        #1;
        obs = {o_state, o_pcWrite, o_adrSrc, o_memRead, o_memWrite, o_irWrite, o_regWrite,
               o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluOp, o_immSrc, o_illegal};
        e = sb_q.pop_front();
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic fd(input string tag, input logic [1:0] imm);
        cyc({tag, "_fetch"},  4'd0, F_RDY, 2'b10, 2'b00, 2'b10, ADD, imm, 1'b0);
        cyc({tag, "_decode"}, 4'd1, NONE,  2'b00, 2'b01, 2'b01, ADD, imm, 1'b0);
    endtask

    task automatic alu(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input logic [3:0] op);
        i_opcode = opc; i_funct3 = f3; i_funct7b5 = f7;
        fd(tag, 2'b00);
        cyc({tag, "_exec"}, (opc == OP_R) ? 4'd6 : 4'd7, NONE, 2'b00, 2'b10,
            (opc == OP_R) ? 2'b00 : 2'b01, op, 2'b00, 1'b0);
        cyc({tag, "_aluwb"}, 4'd8, RW, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b0);
    endtask

    initial begin
        i_arst_n = 1'b0; i_opcode = OP_SW; i_funct3 = 3'b000; i_funct7b5 = 1'b0;
        i_zero = 1'b0; i_memReady = 1'b1;
        #2;
        cyc("reset", 4'd0, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b0);
        i_arst_n = 1'b1;

        // LW, no wait states
        i_opcode = OP_LW;
        fd("lw", 2'b00);
        cyc("lw_memadr",  4'd2, NONE, 2'b00, 2'b10, 2'b01, ADD, 2'b00, 1'b0);
        cyc("lw_memread", 4'd3, MRD,  2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b0);
        cyc("lw_memwb",   4'd4, RW,   2'b01, 2'b00, 2'b00, ADD, 2'b00, 1'b0);

        // LW with one wait state in MEMREAD
        fd("lww", 2'b00);
        cyc("lww_memadr", 4'd2, NONE, 2'b00, 2'b10, 2'b01, ADD, 2'b00, 1'b0);
        i_memReady = 1'b0;
        cyc("lww_memread_wait", 4'd3, MRD, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b0);
        i_memReady = 1'b1;
        cyc("lww_memread", 4'd3, MRD, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b0);
        cyc("lww_memwb",   4'd4, RW,  2'b01, 2'b00, 2'b00, ADD, 2'b00, 1'b0);

        // ALU decode: funct7b5 only selects SUB for R-type
        alu("sub",  OP_R, 3'b000, 1'b1, SUB);
        alu("addi", OP_I, 3'b000, 1'b1, ADD);
        alu("and",  OP_R, 3'b111, 1'b0, AND_);
        alu("ori",  OP_I, 3'b110, 1'b0, OR_);
        alu("xor",  OP_R, 3'b100, 1'b1, XOR_);

        // BEQ taken / not taken
        i_opcode = OP_B; i_funct3 = 3'b000; i_zero = 1'b1;
        fd("beq1", 2'b10);
        cyc("beq_taken", 4'd9, PCW, 2'b00, 2'b10, 2'b00, SUB, 2'b10, 1'b0);
        i_zero = 1'b0;
        fd("beq0", 2'b10);
        cyc("beq_not_taken", 4'd9, NONE, 2'b00, 2'b10, 2'b00, SUB, 2'b10, 1'b0);

        // JAL
        i_opcode = OP_JAL;
        fd("jal", 2'b11);
        cyc("jal_jal",   4'd10, PCW, 2'b00, 2'b01, 2'b10, ADD, 2'b11, 1'b0);
        cyc("jal_aluwb", 4'd8,  RW,  2'b00, 2'b00, 2'b00, ADD, 2'b11, 1'b0);

        // SW with 3 fetch wait states and 2 store wait states
        i_opcode = OP_SW; i_memReady = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("sw_fetch_wait", 4'd0, F_WAIT, 2'b10, 2'b00, 2'b10, ADD, 2'b01, 1'b0);
        i_memReady = 1'b1;
        cyc("sw_fetch", 4'd0, F_RDY, 2'b10, 2'b00, 2'b10, ADD, 2'b01, 1'b0);
        i_memReady = 1'b0;
        cyc("sw_decode", 4'd1, NONE, 2'b00, 2'b01, 2'b01, ADD, 2'b01, 1'b0);
        cyc("sw_memadr", 4'd2, NONE, 2'b00, 2'b10, 2'b01, ADD, 2'b01, 1'b0);
        for (int i = 0; i < 2; i++)
            cyc("sw_memwrite_wait", 4'd5, MWR, 2'b00, 2'b00, 2'b00, ADD, 2'b01, 1'b0);
        i_memReady = 1'b1;
        cyc("sw_memwrite", 4'd5, MWR, 2'b00, 2'b00, 2'b00, ADD, 2'b01, 1'b0);

        // illegal opcode: sticky TRAP, cleared only by reset
        i_opcode = OP_LUI;
        fd("lui", 2'b00);
        cyc("lui_trap", 4'd11, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b1);
        i_memReady = 1'b0;
        cyc("lui_trap_sticky", 4'd11, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b1);
        i_memReady = 1'b1;
        cyc("lui_trap_sticky2", 4'd11, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b1);
        i_arst_n = 1'b0;
        cyc("trap_reset", 4'd0, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b0);
        i_arst_n = 1'b1;

        // I-type with unsupported funct3 traps after EXECI
        i_opcode = OP_I; i_funct3 = 3'b001; i_funct7b5 = 1'b0;
        fd("slli", 2'b00);
        cyc("slli_execi", 4'd7,  NONE, 2'b00, 2'b10, 2'b01, ADD, 2'b00, 1'b0);
        cyc("slli_trap",  4'd11, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b1);
        cyc("slli_trap2", 4'd11, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b1);

`ifdef RISCV_INSTRET_COUNTER_EN
        i_arst_n = 1'b0;
        cyc("cnt_reset", 4'd0, NONE, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1'b0);
        i_arst_n = 1'b1;
        for (int i = 0; i < 17; i++) alu("addi_cnt", OP_I, 3'b000, 1'b0, ADD);
        checks++;
        assert (o_instret === 4'd1) else begin
            errors++;
            $error("FAIL instret_wrap observed=%0d expected=1", o_instret);
        end
        i_opcode = OP_LW;
        fd("lwr", 2'b00);
        cyc("lwr_memadr", 4'd2, NONE, 2'b00, 2'b10, 2'b01, ADD, 2'b00, 1'b0);
        i_arst_n = 1'b0;
        #1;
        checks++;
        assert (o_instret === 4'd0 && o_state === 4'd0) else begin
            errors++;
            $error("FAIL instret_reset observed=%0d/%0d expected=0/0", o_instret, o_state);
        end
        i_arst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Main control unit for the multi-cycle RV32I core, successor to the single-cycle decode package.
- Moore-style FSM sequences each instruction through FETCH..writeback and drives all datapath selects and strobes.
- Adds a memory ready handshake with wait states, illegal-instruction trapping and ALU-op decode; opcode/ALU-op/result encodings come from pa_riscv.

Parameters:
- MEM_HANDSHAKE, 1, 1: memory states wait for i_memReady; 0: i_memReady is ignored (treated as 1).
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- i_clk  in  1  clock, rising edge
- i_arst_n  in  1  asynchronous active-low reset
- i_opcode  in  7  instruction[6:0] from the instruction register
- i_funct3  in  3  instruction[14:12]
- i_funct7b5  in  1  instruction[30]
- i_zero  in  1  ALU zero flag
- i_memReady  in  1  unified memory completes the current access this cycle
- o_pcWrite  out  1  PC register load strobe
- o_adrSrc  out  1  memory address mux: 0 = PC, 1 = ALUOut
- o_memRead  out  1  memory read request
- o_memWrite  out  1  memory write request
- o_irWrite  out  1  instruction/oldPC register load strobe
- o_regWrite  out  1  register-file write strobe
- o_resultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- o_aluSrcA  out  2  ALU A mux: 00 = PC, 01 = oldPC, 10 = rs1
- o_aluSrcB  out  2  ALU B mux: 00 = rs2, 01 = imm, 10 = const 4
- o_aluOp  out  4  ty_ALU_OP value
- o_immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J (from opcode, every state)
- o_illegal  out  1  high while in TRAP
- o_state  out  4  current state encoding, for debug/verification

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Reset (async, !i_arst_n): state = FETCH.
  - While reset is asserted, every strobe (pcWrite, irWrite, regWrite, memRead, memWrite) and o_illegal is forced to 0; all muxes output 00 and o_aluOp = ADD.
  - Reset mid-instruction abandons the instruction; no strobe glitches.
- "rdy" below means i_memReady | ~MEM_HANDSHAKE.
- FETCH:
  - memRead=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=ADD, resultSrc=10.
  - irWrite = pcWrite = rdy.
  - Next state: DECODE if rdy, else stay in FETCH.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=ADD (branch target into ALUOut). Next state by opcode:
  - LW or SW -> MEMADR
  - R_TYPE_ALU -> EXECR
  - I_TYPE_ALU -> EXECI
  - B_TYPE with funct3=000 -> BEQ
  - JAL -> JAL
  - anything else -> TRAP
- MEMADR: aluSrcA=10, aluSrcB=01, ADD. Next: MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: adrSrc=1, memRead=1. Next: MEMWB when rdy, else hold.
- MEMWB: resultSrc=01, regWrite=1. Next: FETCH.
- MEMWRITE: adrSrc=1, memWrite=1, held until rdy. Next: FETCH when rdy.
- EXECR / EXECI: aluSrcA=10, aluSrcB=00 (EXECR) or 01 (EXECI). aluOp from funct3:
  - 000 -> SUB if (EXECR & funct7b5), else ADD
  - 111 -> AND
  - 110 -> OR
  - 100 -> XOR
  - any other funct3 -> TRAP instead of ALUWB
- ALUWB: resultSrc=00, regWrite=1. Next: FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, SUB, resultSrc=00, pcWrite=i_zero. Next: FETCH.
- JAL: aluSrcA=01, aluSrcB=10, ADD (rd = oldPC+4), resultSrc=00, pcWrite=1 (ALUOut holds target). Next: ALUWB.
- TRAP: o_illegal=1, all strobes 0. Sticky until reset.
- Outputs are combinational from state (plus i_zero, i_memReady, opcode, funct fields); no registered-output latency.
- Cycle counts with zero wait states: LW 5, SW 4, R/I 4, BEQ 3, JAL 4. Each wait cycle adds 1.
- i_memReady is sampled only in FETCH/MEMREAD/MEMWRITE and ignored elsewhere.

Optional Feature:
- Macro RISCV_INSTRET_COUNTER_EN.
- Defined: adds port o_instret (out, CNT_W).
  - Async reset to 0.
  - Increments by 1 on the last cycle of each completed instruction: MEMWB, MEMWRITE&rdy, ALUWB, BEQ.
  - Wraps from 2^CNT_W-1 to 0; never increments in TRAP.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- LW (opcode 0000011), i_memReady=1 -> states 0,1,2,3,4,0; regWrite=1 only in MEMWB with resultSrc=01.
- R-type funct3=000, funct7b5=1 -> EXECR aluOp=1000 (SUB); I-type funct3=000, funct7b5=1 -> EXECI aluOp=0000 (ADD).
- BEQ with i_zero=1, then i_zero=0 -> pcWrite=1 vs 0 in state 9; both return to FETCH after 3 cycles.
- MEM_HANDSHAKE=1, i_memReady low 3 cycles in FETCH then SW -> FETCH held 4 cycles, irWrite pulses once; MEMWRITE memWrite held until ready.
- Opcode 0110111, and I-type funct3=001 -> state 11, o_illegal=1 sticky; i_arst_n pulse -> state 0, o_illegal=0.
- With RISCV_INSTRET_COUNTER_EN, CNT_W=4: run 17 ADDI -> o_instret=1; reset mid-LW (state 3) -> o_instret=0, state 0.
